// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// Sequential double-dabble converter: unsigned binary in, packed BCD out, one bit per clock.
// Valid/ready on both sides with a single conversion in flight.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [BIN_W-1:0]   binreg, bin_n;
  logic [BCD_W-1:0]   bcd, bcd_n;
  logic [BCD_W-1:0]   adj;
  logic               ovf_q, ovf_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [BCD_W+BIN_W:0] shifted;

  // Top bit of the shifted word is the carry leaving the highest digit; it feeds sticky ovf.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = bcd[4*d +: 4] + ((bcd[4*d +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
    shifted = {adj, binreg, 1'b0};

    state_n = state;
    bin_n   = binreg;
    bcd_n   = bcd;
    ovf_n   = ovf_q;
    cnt_n   = cnt;

    case (state)
      IDLE: begin
        if (in_valid) begin
          bin_n   = bin_in;
          bcd_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        bin_n = shifted[BIN_W-1:0];
        bcd_n = shifted[BCD_W+BIN_W-1:BIN_W];
        ovf_n = ovf_q | shifted[BCD_W+BIN_W];
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      binreg <= '0;
      bcd    <= '0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      binreg <= bin_n;
      bcd    <= bcd_n;
      ovf_q  <= ovf_n;
      cnt    <= cnt_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bcd_out   = bcd;
  assign ovf       = ovf_q;

endmodule
